// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU that evaluates one 1-bit ALU slice per clock, LSB first.
// Its result, zero, cout and overflow match the parallel ripple ALU built from the same slices.
module alu_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [3:0]       ctrl_r;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;

    logic             accept;
    logic             a1;
    logic             b1;
    logic             sum;
    logic             carry_next;
    logic             res_bit;
    logic             logic_op;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_final;

    // SLT shifts in zeros; its single meaningful bit is patched in on the last cycle.
    function automatic logic slice_bit(input logic [1:0] op, input logic a, input logic b,
                                       input logic s);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return s;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        accept     = start && (state == S_IDLE || state == S_DONE);
        a1         = a_sh[0] ^ ctrl_r[3];
        b1         = b_sh[0] ^ ctrl_r[2];
        sum        = a1 ^ b1 ^ carry;
        carry_next = (a1 & b1) | (a1 & carry) | (b1 & carry);
        res_bit    = slice_bit(ctrl_r[1:0], a1, b1, sum);
        logic_op   = (ctrl_r[1] == 1'b0);
        res_next   = {res_bit, res_sh[WIDTH-1:1]};
        res_final  = res_next;
        if (ctrl_r[1:0] == 2'b11) begin
            res_final[0] = sum;
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            state <= S_RUN;
            cnt   <= '0;
            carry <= ctrl[2];
        end else if (state == S_RUN) begin
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
                state    <= S_DONE;
                result   <= res_final;
                zero     <= (res_final == '0);
                cout     <= logic_op ? 1'b0 : carry_next;
                overflow <= logic_op ? 1'b0 : (carry ^ carry_next);
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
    end

    // Operand and partial-result shifters carry no reset; state gates their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh   <= src1;
            b_sh   <= src2;
            ctrl_r <= ctrl;
            res_sh <= '0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
        end
    end

endmodule
